// File: rtl/vec_lane_scheduler.sv
// Round-robin scheduler sharing one lane-wise vector unit (PASS/REV/AND/XOR) among NUM_REQ requesters.
// Optional perf counters are enabled with `define VEC_LANE_SCHED_PERF_EN.
module vec_lane_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id
`ifdef VEC_LANE_SCHED_PERF_EN
  ,
  output logic [15:0]              perf_grants,
  output logic [15:0]              perf_stalls
`endif
);

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_REV  = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_XOR  = 2'd3;

  typedef enum logic {EMPTY, FULL} state_t;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < WIDTH; k++) r[k] = v[WIDTH-1-k];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] lane_op(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_PASS: r = a;
      OP_REV:  r = bit_rev(a);
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_p1;
  logic              resp_valid_p1;
  logic [WIDTH-1:0]  resp_data_p1;
  logic [ID_W-1:0]   resp_id_p1;
  logic [ID_W-1:0]   rr_ptr;

  logic              can_issue;
  logic              vld_p0;
  logic [ID_W-1:0]   grant_id_p0;
  logic [WIDTH-1:0]  result_p0;
  logic [ID_W-1:0]   rr_next;

  assign can_issue = (state_p1 == EMPTY) | resp_ready;

  // Stage p0: rotating priority scan from rr_ptr; grant suppressed while in reset or stalled
  always_comb begin
    int idx;
    idx         = 0;
    vld_p0      = 1'b0;
    grant_id_p0 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!vld_p0 && req_valid[idx]) begin
        vld_p0      = 1'b1;
        grant_id_p0 = ID_W'(idx);
      end
    end
    if (!can_issue || !rst_n) vld_p0 = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (vld_p0) req_ready[grant_id_p0] = 1'b1;
  end

  always_comb begin
    int g;
    g         = int'(grant_id_p0);
    result_p0 = lane_op(req_op[2*g +: 2], req_a[WIDTH*g +: WIDTH], req_b[WIDTH*g +: WIDTH]);
  end

  assign rr_next = (grant_id_p0 == ID_W'(NUM_REQ-1)) ? '0 : grant_id_p0 + ID_W'(1);

  // Stage p1: single-entry response register and EMPTY/FULL control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1      <= EMPTY;
      resp_valid_p1 <= 1'b0;
      resp_data_p1  <= '0;
      resp_id_p1    <= '0;
      rr_ptr        <= '0;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (vld_p0) begin
            state_p1      <= FULL;
            resp_valid_p1 <= 1'b1;
          end
        end
        FULL: begin
          if (resp_ready && !vld_p0) begin
            state_p1      <= EMPTY;
            resp_valid_p1 <= 1'b0;
          end
        end
        default: begin
          state_p1      <= EMPTY;
          resp_valid_p1 <= 1'b0;
        end
      endcase
      if (vld_p0) begin
        resp_data_p1 <= result_p0;
        resp_id_p1   <= grant_id_p0;
        rr_ptr       <= rr_next;
      end
    end
  end

  assign resp_valid = resp_valid_p1;
  assign resp_data  = resp_data_p1;
  assign resp_id    = resp_id_p1;

`ifdef VEC_LANE_SCHED_PERF_EN
  logic [15:0] grants_cnt;
  logic [15:0] stalls_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_cnt <= '0;
      stalls_cnt <= '0;
    end else begin
      if (vld_p0) grants_cnt <= sat_inc(grants_cnt);
      if (resp_valid_p1 && !resp_ready) stalls_cnt <= sat_inc(stalls_cnt);
    end
  end

  assign perf_grants = grants_cnt;
  assign perf_stalls = stalls_cnt;
`else
  logic [15:0] unused_sat;
  assign unused_sat = sat_inc(16'd0);
`endif

endmodule

// File: doc/vec_lane_scheduler.md
Name: vec_lane_scheduler

Overview:
- Round-robin scheduler that shares one lane-wise vector unit (pass, bit-reverse, AND, XOR) among NUM_REQ requesters.
- Sits in front of the vectorized bit-parallel datapath produced by the hw-vectorization flow.
- Presents valid/ready request channels and a single registered response channel tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- WIDTH, 8, lane count (bits per operand); range 1..64.
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]: 0 PASS (a), 1 REV (a bit-reversed, out[k]=a[WIDTH-1-k]), 2 AND (a&b), 3 XOR (a^b).
- req_a  in  WIDTH*NUM_REQ  operand a, slice i.
- req_b  in  WIDTH*NUM_REQ  operand b, slice i; ignored for PASS/REV.
- resp_valid  out  1  response register full.
- resp_ready  in  1  downstream accept.
- resp_data  out  WIDTH  registered result.
- resp_id  out  ID_W  index of the requester that produced resp_data.

Behaviour:
- Reset (async assert, sync-released use): resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0, state=EMPTY. req_ready is combinational and is 0 while in reset.
- FSM: EMPTY (no response held) and FULL (response held).
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY when resp_ready=1 and no grant.
  - FULL stays FULL when resp_ready=0, or when resp_ready=1 with a grant (back-to-back).
- can_issue = (state==EMPTY) | resp_ready.
- Arbitration, combinational: scan requesters starting at rr_ptr, wrapping modulo NUM_REQ. The first i with req_valid[i]=1 wins when can_issue=1.
  - req_ready[i]=1 only for the winner.
  - Transfer on a requester = req_valid & req_ready.
- On a grant to requester g:
  - resp_data <= op(g); resp_id <= g; resp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
- No grant: rr_ptr holds.
- Latency: 1 cycle from request transfer to resp_valid.
- Throughput: 1 result/cycle while resp_ready=1.
- Stall: resp_valid=1 and resp_ready=0 means all req_ready=0. resp_data and resp_id hold stable until accepted.
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- Requester requirements: a requester holds req_valid, req_op, req_a and req_b stable until its transfer. The block does not check this.
- Results are computed combinationally from the granted slice and registered. Width is exactly WIDTH, no carries.
- Simultaneous downstream accept and new grant in one cycle: the old response retires and the new one loads. No bubble and no loss.
- Reset mid-operation: a held response is discarded and rr_ptr returns to 0.

Optional Feature:
- Macro VEC_LANE_SCHED_PERF_EN.
- When defined, adds two output ports:
  - perf_grants (16-bit): counts grants.
  - perf_stalls (16-bit): counts cycles with resp_valid=1 and resp_ready=0.
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent and the core behaviour is identical.

Test Plan:
- Single op: NUM_REQ=4, WIDTH=8, req_valid=4'b0100, slice2 op=1, a=8'b1100_0001, resp_ready=1 -> next cycle resp_valid=1, resp_data=8'b1000_0011, resp_id=2; rr_ptr becomes 3.
- Round-robin: all four requesters valid continuously, op=3, a=8'hF0 and b=8'h0F for all, resp_ready=1 -> resp_id sequence 0,1,2,3,0; every resp_data=8'hFF; one result per cycle.
- Backpressure: hold resp_ready=0 with the response FULL for 3 cycles -> req_ready=0, and resp_data/resp_id unchanged for all 3 cycles. Then raise resp_ready -> same-cycle accept and the next grant loads without a bubble.
- Wrap and skip: rr_ptr=3 and only requester 1 valid, op=2, a=8'hAA, b=8'h3C -> requester 1 granted, resp_data=8'h28, rr_ptr becomes 2.
- Async reset mid-stream: assert rst_n=0 while FULL -> resp_valid=0 immediately without waiting for a clock edge; after release the first grant goes to the lowest valid index ≥0.
- Perf, with VEC_LANE_SCHED_PERF_EN: 5 grants and 3 stall cycles -> perf_grants=5, perf_stalls=3. Force 70000 stall cycles -> perf_stalls=16'hFFFF.
